// File: rtl/axis_pkg.sv
// Shared constants and beat layout for the AXI-Stream FIFO.
// The top rebuilds the same {last, data} packing at its own DATA_W.
package axis_pkg;

  localparam int AXIS_DATA_W_DEF = 32;
  localparam int AXIS_DEPTH_DEF  = 16;

  // One stored beat: tlast in the MSB, tdata below it.
  typedef struct packed {
    logic                       last;
    logic [AXIS_DATA_W_DEF-1:0] data;
  } axis_beat_t;

endpackage

// File: rtl/axis_fifo_mem.sv
// Beat storage for axis_fifo: DEPTH x W, synchronous write, asynchronous read.
// Holds no control state; pointers and occupancy live in the top.
module axis_fifo_mem #(
  parameter int W     = 33,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          axi_clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];

  // Write port: contents are never reset, stale entries are unreachable.
  always_ff @(posedge axi_clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Read port is combinational so the head beat falls through to m_axis.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/axis_fifo.sv
// First-word-fall-through AXI-Stream FIFO with packet counting.
// Define AXIS_FIFO_PKT_MODE_EN for store-and-forward: output is held off
// until a whole packet is stored, or the FIFO is full (oversize cut-through).
module axis_fifo
  import axis_pkg::*;
#(
  parameter int DATA_W = AXIS_DATA_W_DEF,
  parameter int DEPTH  = AXIS_DEPTH_DEF
) (
  input  logic                       axi_clk,
  input  logic                       axi_resetn,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  input  logic [DATA_W-1:0]          s_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [DATA_W-1:0]          m_axis_tdata,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic [$clog2(DEPTH):0]     pkt_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d, pkt_q, pkt_d;
  logic          rdy_q;
  logic          wr_en, rd_en, out_vld, rd_last;
  logic [DATA_W:0] wr_beat, rd_beat;

  // rdy_q keeps tready low during reset and until the first clock after it.
  assign s_axis_tready = rdy_q && (count_q < FULL_CNT);

`ifdef AXIS_FIFO_PKT_MODE_EN
  assign out_vld = (pkt_q != '0) || (count_q == FULL_CNT);
`else
  assign out_vld = (count_q != '0);
`endif

  assign wr_en   = s_axis_tvalid && s_axis_tready;
  assign rd_en   = out_vld && m_axis_tready;
  assign wr_beat = {s_axis_tlast, s_axis_tdata};
  assign rd_last = rd_beat[DATA_W];

  assign m_axis_tvalid = out_vld;
  assign m_axis_tdata  = out_vld ? rd_beat[DATA_W-1:0] : '0;
  assign m_axis_tlast  = out_vld && rd_last;
  assign fill_level    = count_q;
  assign pkt_count     = pkt_q;

  axis_fifo_mem #(.W(DATA_W + 1), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .axi_clk (axi_clk),
    .we      (wr_en),
    .waddr   (wr_ptr_q),
    .wdata   (wr_beat),
    .raddr   (rd_ptr_q),
    .rdata   (rd_beat)
  );

  // Next-state: pointers wrap naturally at AW bits, counts net out push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pkt_d    = pkt_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    case ({wr_en && s_axis_tlast, rd_en && rd_last})
      2'b10:   pkt_d = pkt_q + 1'b1;
      2'b01:   pkt_d = pkt_q - 1'b1;
      default: pkt_d = pkt_q;
    endcase
  end

  // State registers; reset drops every stored beat by zeroing occupancy.
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pkt_q    <= '0;
      rdy_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pkt_q    <= pkt_d;
      rdy_q    <= 1'b1;
    end
  end

endmodule
